// File: rtl/pipe_hazard_sched_if.sv
// Decoder/pipeline-side signals of the hazard scheduler: ID/EX/MEM observations in,
// pipeline-register enables, flushes and MUL handshakes out.
interface pipe_hazard_sched_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_cmp;
  logic       id_jump;
  logic       ex_lw;
  logic       ex_mul;
  logic       ex_rf_w_ena;
  logic [4:0] ex_waddr;
  logic       mem_lw;
  logic [4:0] mem_waddr;

  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_stall;
  logic       ex_mem_bubble;
  logic       mul_start;
  logic       mul_done;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_cmp, id_jump,
    output ex_lw, ex_mul, ex_rf_w_ena, ex_waddr, mem_lw, mem_waddr,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    input  ex_stall, ex_mem_bubble, mul_start, mul_done
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_cmp, id_jump,
    input  ex_lw, ex_mul, ex_rf_w_ena, ex_waddr, mem_lw, mem_waddr,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    output ex_stall, ex_mem_bubble, mul_start, mul_done
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Stall/flush scheduler for load-use, ID-branch and multi-cycle MUL hazards; HAZARD_PERF_CNT_EN adds stall/flush counters.
// Controls are combinational from registered state and inputs; a MUL freezes the front end for MUL_LAT-1 cycles.
module pipe_hazard_sched #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_sched_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  localparam bit         MUL_MULTI = (MUL_LAT > 1);
  localparam int         CNT_INIT  = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam [CNT_W-1:0] CNT_LOAD  = CNT_W'(CNT_INIT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_rs_ok;
  logic w_rt_ok;
  logic w_match_ex;
  logic w_match_mem;
  logic w_load_use;
  logic w_cmp_haz;
  logic w_hazard;
  logic w_mul_last;

  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_stall;
  logic w_ex_mem_bubble;
  logic w_mul_start;
  logic w_mul_done;

  // $0 is never a real dependency; JR vs BEQ/BNE is expressed through id_use_rt.
  assign w_rs_ok = bus.id_valid & bus.id_use_rs & (bus.id_rs != 5'd0);
  assign w_rt_ok = bus.id_valid & bus.id_use_rt & (bus.id_rt != 5'd0);

  assign w_match_ex  = (w_rs_ok & (bus.id_rs == bus.ex_waddr)) |
                       (w_rt_ok & (bus.id_rt == bus.ex_waddr));
  assign w_match_mem = (w_rs_ok & (bus.id_rs == bus.mem_waddr)) |
                       (w_rt_ok & (bus.id_rt == bus.mem_waddr));

  assign w_load_use = bus.ex_lw & bus.ex_rf_w_ena & w_match_ex;
  assign w_cmp_haz  = bus.id_cmp & ((bus.ex_rf_w_ena & w_match_ex) |
                                    (bus.mem_lw & w_match_mem));
  assign w_hazard   = w_load_use | w_cmp_haz;

  assign w_mul_last = (r_state == MUL_BUSY) && (r_cnt == '0);

  always_comb begin
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_stall      = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mul_start     = 1'b0;
    w_mul_done      = 1'b0;
    if (rst_n) begin
      if (r_state == MUL_BUSY) begin
        // On the last busy cycle EX is released so the product moves on.
        w_pc_stall      = 1'b1;
        w_if_id_stall   = 1'b1;
        w_ex_stall      = ~w_mul_last;
        w_ex_mem_bubble = ~w_mul_last;
        w_mul_done      = w_mul_last;
      end else begin
        w_pc_stall      = w_hazard;
        w_if_id_stall   = w_hazard;
        w_id_ex_bubble  = w_hazard;
        w_if_id_flush   = ~w_hazard & bus.id_jump & bus.id_valid;
        w_mul_start     = bus.ex_mul;
        w_mul_done      = bus.ex_mul & ~MUL_MULTI;
      end
    end
  end

  assign bus.pc_stall      = w_pc_stall;
  assign bus.if_id_stall   = w_if_id_stall;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_bubble  = w_id_ex_bubble;
  assign bus.ex_stall      = w_ex_stall;
  assign bus.ex_mem_bubble = w_ex_mem_bubble;
  assign bus.mul_start     = w_mul_start;
  assign bus.mul_done      = w_mul_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ex_mul && MUL_MULTI) begin
            r_state <= MUL_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        MUL_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_pc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_if_id_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed plus random bench for pipe_hazard_sched against a cycle-indexed reference model.
module tb_pipe_hazard_sched;
  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_sched_if bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
`endif

  pipe_hazard_sched #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int mul_t0 = -1;   // cycle in which the active MUL issued mul_start

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit id_reads(input logic [4:0] r);
    return bus.id_valid && (r != 5'd0) &&
           ((bus.id_use_rs && bus.id_rs == r) || (bus.id_use_rt && bus.id_rt == r));
  endfunction

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_stall, ex_mem_bubble, mul_start, mul_done}
  function automatic logic [7:0] expect_out(input bit in_mul, input bit last);
    bit haz;
    if (!rst_n) return 8'h00;
    if (in_mul) return {1'b1, 1'b1, 1'b0, 1'b0, !last, !last, 1'b0, last};
    haz = (bus.ex_lw && bus.ex_rf_w_ena && id_reads(bus.ex_waddr)) ||
          (bus.id_cmp && ((bus.ex_rf_w_ena && id_reads(bus.ex_waddr)) ||
                          (bus.mem_lw && id_reads(bus.mem_waddr))));
    return {haz, haz, (!haz && bus.id_jump && bus.id_valid), haz,
            1'b0, 1'b0, bus.ex_mul, (bus.ex_mul && MUL_LAT == 1)};
  endfunction

  task automatic clear_in();
    bus.id_valid    = 1'b0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.id_cmp      = 1'b0;
    bus.id_jump     = 1'b0;
    bus.ex_lw       = 1'b0;
    bus.ex_mul      = 1'b0;
    bus.ex_rf_w_ena = 1'b0;
    bus.ex_waddr    = 5'd0;
    bus.mem_lw      = 1'b0;
    bus.mem_waddr   = 5'd0;
  endtask

  // Called at posedge+1 with inputs already applied; compares, advances the model, then the clock.
  task automatic step(input string tag);
    logic [7:0] e;
    logic [7:0] o;
    bit in_mul;
    bit last;
    #3;
    in_mul = rst_n && (mul_t0 >= 0) && (cyc > mul_t0) && (cyc <= mul_t0 + MUL_LAT - 1);
    last   = (cyc == mul_t0 + MUL_LAT - 1);
    e = expect_out(in_mul, last);
    o = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_bubble,
         bus.ex_stall, bus.ex_mem_bubble, bus.mul_start, bus.mul_done};
    check(tag, {24'd0, o}, {24'd0, e});
    if (!rst_n) begin
      mul_t0 = -1;
`ifdef HAZARD_PERF_CNT_EN
      m_stall = 0;
      m_flush = 0;
`endif
    end else begin
      if (!in_mul && bus.ex_mul && MUL_LAT > 1) mul_t0 = cyc;
`ifdef HAZARD_PERF_CNT_EN
      m_stall += int'(e[7]);
      m_flush += int'(e[5]);
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cycles, m_stall);
    check({tag, "_flush_cnt"}, flush_count, m_flush);
`endif
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset forces every output low even with hazards and a MUL presented.
    bus.ex_mul = 1'b1; bus.id_valid = 1'b1; bus.id_jump = 1'b1;
    bus.ex_lw = 1'b1; bus.ex_rf_w_ena = 1'b1; bus.ex_waddr = 5'd2;
    bus.id_rs = 5'd2; bus.id_use_rs = 1'b1;
    step("reset0");
    step("reset1");
    clear_in();
    rst_n = 1'b1;
    step("idle");

    // LW $3 in EX, ADD reading rt=$3 in ID.
    bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd3;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    bus.ex_lw = 1'b1; bus.ex_rf_w_ena = 1'b1; bus.ex_waddr = 5'd3;
    step("load_use");
    bus.ex_lw = 1'b0; bus.ex_rf_w_ena = 1'b0; bus.ex_waddr = 5'd0;
    bus.mem_lw = 1'b1; bus.mem_waddr = 5'd3;
    step("load_use_gone");
    clear_in();

    bus.id_valid = 1'b1; bus.id_jump = 1'b1;
    step("jump_flush");
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_one", stall_cycles, 32'd1);
    check("perf_flush_one", flush_count, 32'd1);
`endif
    clear_in();
    bus.id_jump = 1'b1;
    step("jump_invalid_id");

    // BEQ $4,$5 behind LW $5: EX match, then MEM match, then flush.
    bus.id_valid = 1'b1; bus.id_cmp = 1'b1; bus.id_jump = 1'b1;
    bus.id_rs = 5'd4; bus.id_rt = 5'd5; bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    bus.ex_lw = 1'b1; bus.ex_rf_w_ena = 1'b1; bus.ex_waddr = 5'd5;
    step("beq_ex");
    bus.ex_lw = 1'b0; bus.ex_rf_w_ena = 1'b0; bus.ex_waddr = 5'd0;
    bus.mem_lw = 1'b1; bus.mem_waddr = 5'd5;
    step("beq_mem");
    bus.mem_lw = 1'b0; bus.mem_waddr = 5'd0;
    step("beq_flush");

    // JR behind an ALU op writing its rs.
    clear_in();
    bus.id_valid = 1'b1; bus.id_cmp = 1'b1; bus.id_jump = 1'b1;
    bus.id_rs = 5'd9; bus.id_use_rs = 1'b1; bus.id_rt = 5'd9;
    bus.ex_rf_w_ena = 1'b1; bus.ex_waddr = 5'd9;
    step("jr_alu");
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    step("jr_no_use");

    // $0 and unused operands never match.
    clear_in();
    bus.id_valid = 1'b1; bus.id_rs = 5'd0; bus.id_use_rs = 1'b1;
    bus.ex_lw = 1'b1; bus.ex_rf_w_ena = 1'b1; bus.ex_waddr = 5'd0;
    step("zero_reg");
    bus.id_rs = 5'd7; bus.id_use_rs = 1'b0; bus.ex_waddr = 5'd7;
    step("use_rs_off");
    clear_in();

    // MUL with hazards and a second ex_mul presented while busy.
    bus.ex_mul = 1'b1;
    step("mul_c0");
    bus.ex_mul = 1'b0;
    bus.id_valid = 1'b1; bus.id_jump = 1'b1; bus.id_rt = 5'd6; bus.id_use_rt = 1'b1;
    bus.ex_lw = 1'b1; bus.ex_rf_w_ena = 1'b1; bus.ex_waddr = 5'd6;
    step("mul_c1");
    bus.ex_mul = 1'b1;
    step("mul_c2");
    step("mul_c3_done");
    clear_in();
    step("mul_c4_idle");

    // Reset in the middle of a MUL, then a clean restart.
    bus.ex_mul = 1'b1;
    step("mulr_c0");
    bus.ex_mul = 1'b0;
    step("mulr_c1");
    rst_n = 1'b0;
    step("mulr_c2_rst");
    rst_n = 1'b1;
    step("mulr_c3_no_done");
    bus.ex_mul = 1'b1;
    step("mulr_restart");
    bus.ex_mul = 1'b0;
    step("mulr_b1");
    step("mulr_b2");
    step("mulr_b3");
    step("mulr_idle");

    for (int i = 0; i < 600; i++) begin
      rst_n           = ($urandom_range(0, 59) != 0);
      bus.id_valid    = ($urandom_range(0, 7) != 0);
      bus.id_rs       = 5'($urandom_range(0, 3));
      bus.id_rt       = 5'($urandom_range(0, 3));
      bus.id_use_rs   = $urandom_range(0, 1) == 1;
      bus.id_use_rt   = $urandom_range(0, 1) == 1;
      bus.id_cmp      = ($urandom_range(0, 2) == 0);
      bus.id_jump     = ($urandom_range(0, 2) == 0);
      bus.ex_lw       = ($urandom_range(0, 2) == 0);
      bus.ex_mul      = ($urandom_range(0, 9) == 0);
      bus.ex_rf_w_ena = $urandom_range(0, 1) == 1;
      bus.ex_waddr    = 5'($urandom_range(0, 3));
      bus.mem_lw      = ($urandom_range(0, 2) == 0);
      bus.mem_waddr   = 5'($urandom_range(0, 3));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
